// File: rtl/chdr_xb_egress_arbiter.sv
// Packet-atomic round-robin arbiter for one crossbar egress port (grant held first beat to tlast).
// Optional statistics outputs (pkt_count, stall_cycles) are built when CHDR_XB_ARB_STATS_EN is defined.
module chdr_xb_egress_arbiter #(
  parameter int NUM_PORTS = 10,
  parameter int DWIDTH    = 64,
  localparam int SELW     = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        port_mask,
  input  logic [NUM_PORTS*DWIDTH-1:0] in_tdata,
  input  logic [NUM_PORTS-1:0]        in_tlast,
  input  logic [NUM_PORTS-1:0]        in_tvalid,
  output logic [NUM_PORTS-1:0]        in_tready,
  output logic [DWIDTH-1:0]           out_tdata,
  output logic                        out_tlast,
  output logic                        out_tvalid,
  input  logic                        out_tready,
  output logic [SELW-1:0]             grant_idx,
  output logic                        busy
`ifdef CHDR_XB_ARB_STATS_EN
  ,
  output logic [31:0]                 pkt_count,
  output logic [31:0]                 stall_cycles
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [SELW-1:0]   grant_q, grant_d;
  logic [SELW-1:0]   last_q, last_d;
  logic [NUM_PORTS-1:0] req, arbReq;
  logic [SELW-1:0]   winner;
  logic              found;
  logic              eop;
  logic [SELW:0]     scanIdx;
  logic [DWIDTH-1:0] selData;

  assign req = in_tvalid & port_mask;

  // The held port is excluded at end of packet so it cannot be regranted back-to-back.
  always_comb begin
    arbReq = req;
    if (state_q == BUSY) arbReq[grant_q] = 1'b0;
  end

  always_comb begin
    found   = 1'b0;
    winner  = '0;
    scanIdx = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      scanIdx = {1'b0, last_q} + (SELW+1)'(k);
      if (scanIdx >= (SELW+1)'(NUM_PORTS)) scanIdx = scanIdx - (SELW+1)'(NUM_PORTS);
      if (!found && arbReq[scanIdx[SELW-1:0]]) begin
        found  = 1'b1;
        winner = scanIdx[SELW-1:0];
      end
    end
  end

  always_comb begin
    selData = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_q == SELW'(p)) selData = in_tdata[p*DWIDTH +: DWIDTH];
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    out_tdata  = '0;
    out_tlast  = 1'b0;
    out_tvalid = 1'b0;
    in_tready  = '0;
    eop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = BUSY;
          grant_d = winner;
          last_d  = winner;
        end
      end
      BUSY: begin
        out_tdata          = selData;
        out_tlast          = in_tlast[grant_q];
        out_tvalid         = in_tvalid[grant_q];
        in_tready[grant_q] = out_tready;
        eop                = in_tvalid[grant_q] & out_tready & in_tlast[grant_q];
        if (eop) begin
          if (found) begin
            grant_d = winner;
            last_d  = winner;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= SELW'(NUM_PORTS-1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign grant_idx = grant_q;
  assign busy      = (state_q == BUSY);

`ifdef CHDR_XB_ARB_STATS_EN
  logic [31:0] pkt_count_q, stall_q;

  // Packet count wraps naturally; stall count saturates at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count_q <= '0;
      stall_q     <= '0;
    end else begin
      if (eop) pkt_count_q <= pkt_count_q + 32'd1;
      if (out_tvalid && !out_tready && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
    end
  end

  assign pkt_count    = pkt_count_q;
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_chdr_xb_egress_arbiter.sv
// Self-checking bench for chdr_xb_egress_arbiter: vector table, directed sequences, random traffic vs model.
// Stats checks are compiled in when CHDR_XB_ARB_STATS_EN is defined.
module tb_chdr_xb_egress_arbiter;
  localparam int NP = 10;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic reset;
  logic [NP-1:0]    port_mask;
  logic [NP*DW-1:0] in_tdata;
  logic [NP-1:0]    in_tlast, in_tvalid, in_tready;
  logic [DW-1:0]    out_tdata;
  logic             out_tlast, out_tvalid, out_tready;
  logic [3:0]       grant_idx;
  logic             busy;
`ifdef CHDR_XB_ARB_STATS_EN
  logic [31:0]      pkt_count, stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chdr_xb_egress_arbiter #(.NUM_PORTS(NP), .DWIDTH(DW)) dut (
    .clk(clk), .reset(reset), .port_mask(port_mask),
    .in_tdata(in_tdata), .in_tlast(in_tlast), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tlast(out_tlast), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .grant_idx(grant_idx), .busy(busy)
`ifdef CHDR_XB_ARB_STATS_EN
    , .pkt_count(pkt_count), .stall_cycles(stall_cycles)
`endif
  );

  typedef struct {
    int         prime;
    logic [9:0] mask;
    logic [9:0] valid;
    logic       expBusy;
    logic [3:0] expGrant;
  } vec_t;

  vec_t vecs[11];

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic stepClk;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic applyReset;
    port_mask  = '1;
    in_tdata   = '0;
    in_tlast   = '0;
    in_tvalid  = '0;
    out_tready = 1'b0;
    reset      = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  function automatic logic [63:0] beatWord(input int p, input int pkt, input int beat);
    return {8'(p), 24'(pkt), 32'(beat)};
  endfunction

  // Round-robin reference: nearest requester strictly after 'last', going upward with wrap.
  function automatic int pick(input logic [NP-1:0] r, input int last);
    int best = -1;
    int bestD = NP;
    for (int p = 0; p < NP; p++) begin
      if (r[p]) begin
        int d;
        d = (p - last - 1 + 2*NP) % NP;
        if (d < bestD) begin
          bestD = d;
          best  = p;
        end
      end
    end
    return best;
  endfunction

  task automatic applyStimulus(input vec_t v);
    applyReset();
    if (v.prime >= 0) begin
      in_tvalid  = NP'(1) << v.prime;
      in_tlast   = '1;
      out_tready = 1'b1;
      stepClk();
      stepClk();
    end
    port_mask  = v.mask;
    in_tvalid  = v.valid;
    in_tlast   = '0;
    out_tready = 1'b1;
    stepClk();
    settle();
  endtask

  task automatic checkOutput(input vec_t v, input int n);
    logic [NP-1:0] expRdy;
    expRdy = v.expBusy ? (NP'(1) << v.expGrant) : '0;
    checkVal($sformatf("vec%0d_busy", n), busy, v.expBusy);
    checkVal($sformatf("vec%0d_grant", n), grant_idx, v.expGrant);
    checkVal($sformatf("vec%0d_tvalid", n), out_tvalid, v.expBusy);
    checkVal($sformatf("vec%0d_tready", n), in_tready, expRdy);
  endtask

  int bc[NP];
  int remaining[NP], beatI[NP], plen[NP], pktI[NP];
  int mBusy, mGrant, mLast, total, gotBeats, cycles, left, g;
  logic [NP-1:0] req, r2, expRdy;
  logic hs, eopM;

  initial begin
    vecs[0]  = '{-1, 10'h3FF, 10'h000, 1'b0, 4'd0};
    vecs[1]  = '{-1, 10'h3FF, 10'h3FF, 1'b1, 4'd0};
    vecs[2]  = '{-1, 10'h3FF, 10'h208, 1'b1, 4'd3};
    vecs[3]  = '{-1, 10'h200, 10'h208, 1'b1, 4'd9};
    vecs[4]  = '{ 4, 10'h3FF, 10'h3FF, 1'b1, 4'd5};
    vecs[5]  = '{ 9, 10'h3FF, 10'h3FF, 1'b1, 4'd0};
    vecs[6]  = '{ 4, 10'h3FF, 10'h00C, 1'b1, 4'd2};
    vecs[7]  = '{ 4, 10'h3FF, 10'h010, 1'b1, 4'd4};
    vecs[8]  = '{ 7, 10'h0FF, 10'h3FF, 1'b1, 4'd0};
    vecs[9]  = '{ 2, 10'h3FF, 10'h000, 1'b0, 4'd2};
    vecs[10] = '{ 6, 10'h3FF, 10'h0C0, 1'b1, 4'd7};

    // Idle after reset
    applyReset();
    for (int c = 0; c < 20; c++) begin
      settle();
      checkVal("t1_tvalid", out_tvalid, 0);
      checkVal("t1_tready", in_tready, 0);
      checkVal("t1_busy", busy, 0);
      checkVal("t1_grant", grant_idx, 0);
      stepClk();
    end

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // Single 4-beat packet from port 3
    applyReset();
    in_tvalid  = 10'h008;
    out_tready = 1'b1;
    in_tdata[3*DW +: DW] = beatWord(3, 0, 0);
    settle();
    checkVal("t2_idle_busy", busy, 0);
    checkVal("t2_idle_tready", in_tready, 0);
    stepClk();
    for (int k = 0; k < 4; k++) begin
      in_tdata[3*DW +: DW] = beatWord(3, 0, k);
      in_tlast[3] = (k == 3);
      settle();
      checkVal("t2_busy", busy, 1);
      checkVal("t2_tvalid", out_tvalid, 1);
      checkVal("t2_data", out_tdata, beatWord(3, 0, k));
      checkVal("t2_tlast", out_tlast, (k == 3));
      checkVal("t2_tready", in_tready, 10'h008);
      checkVal("t2_grant", grant_idx, 3);
      stepClk();
    end
    in_tvalid = '0;
    settle();
    checkVal("t2_end_busy", busy, 0);
    checkVal("t2_end_grant", grant_idx, 3);

    // All ports streaming 2-beat packets back to back
    applyReset();
    in_tvalid  = '1;
    out_tready = 1'b1;
    for (int p = 0; p < NP; p++) bc[p] = 0;
    for (int c = -1; c < 40; c++) begin
      for (int p = 0; p < NP; p++) begin
        in_tdata[p*DW +: DW] = beatWord(p, 0, bc[p]);
        in_tlast[p] = (bc[p] == 1);
      end
      settle();
      if (c < 0) begin
        checkVal("t3_first_busy", busy, 0);
      end else begin
        g = (c / 2) % NP;
        checkVal("t3_busy", busy, 1);
        checkVal("t3_grant", grant_idx, g);
        checkVal("t3_tlast", out_tlast, c % 2);
        checkVal("t3_data", out_tdata, beatWord(g, 0, c % 2));
        bc[g] = 1 - bc[g];
      end
      stepClk();
    end
`ifdef CHDR_XB_ARB_STATS_EN
    checkVal("t3_pkt_count", pkt_count, 20);
`endif

    // Masked port becomes eligible during another port's packet
    applyReset();
    port_mask  = 10'h3DF;
    in_tvalid  = 10'h024;
    out_tready = 1'b1;
    in_tdata[5*DW +: DW] = beatWord(5, 0, 0);
    for (int b = -1; b < 3; b++) begin
      in_tdata[2*DW +: DW] = beatWord(2, 0, (b < 0) ? 0 : b);
      in_tlast[2] = (b == 2);
      settle();
      if (b >= 0) begin
        checkVal("t4_grant", grant_idx, 2);
        checkVal("t4_data", out_tdata, beatWord(2, 0, b));
        checkVal("t4_tready", in_tready, 10'h004);
        if (b == 0) port_mask = '1;
      end
      stepClk();
    end
    in_tvalid = 10'h020;
    settle();
    checkVal("t4_next_busy", busy, 1);
    checkVal("t4_next_grant", grant_idx, 5);
    checkVal("t4_next_data", out_tdata, beatWord(5, 0, 0));
    checkVal("t4_next_tready", in_tready, 10'h020);

    // Reset asserted mid-packet
    applyReset();
    in_tvalid  = 10'h001;
    out_tready = 1'b1;
    in_tdata[0 +: DW] = beatWord(0, 0, 0);
    stepClk();
    stepClk();
    in_tdata[0 +: DW] = beatWord(0, 0, 1);
    settle();
    checkVal("t6_pre_busy", busy, 1);
    reset = 1'b1;
    #1;
    checkVal("t6_rst_tvalid", out_tvalid, 0);
    checkVal("t6_rst_tready", in_tready, 0);
    checkVal("t6_rst_busy", busy, 0);
    checkVal("t6_rst_grant", grant_idx, 0);
    checkVal("t6_rst_tdata", out_tdata, 0);
    checkVal("t6_rst_tlast", out_tlast, 0);
`ifdef CHDR_XB_ARB_STATS_EN
    checkVal("t6_rst_pkt_count", pkt_count, 0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    in_tvalid = '1;
    in_tlast  = '1;
    for (int p = 0; p < NP; p++) in_tdata[p*DW +: DW] = beatWord(p, 1, 0);
    stepClk();
    settle();
    checkVal("t6_after_busy", busy, 1);
    checkVal("t6_after_grant", grant_idx, 0);
    checkVal("t6_after_data", out_tdata, beatWord(0, 1, 0));
    stepClk();
`ifdef CHDR_XB_ARB_STATS_EN
    checkVal("t6_after_pkt_count", pkt_count, 1);
`endif

    // Random traffic, random backpressure and mask against the reference model
    applyReset();
    mBusy = 0; mGrant = 0; mLast = NP-1;
    total = 0; gotBeats = 0; cycles = 0;
    for (int p = 0; p < NP; p++) begin
      remaining[p] = 20; beatI[p] = 0; pktI[p] = 0;
      plen[p] = $urandom_range(1, 8);
      total += plen[p];
    end
    left = NP;
    while (left > 0 && cycles < 20000) begin
      for (int p = 0; p < NP; p++) begin
        if (remaining[p] > 0) begin
          in_tvalid[p] = ($urandom_range(0, 3) != 0);
          in_tdata[p*DW +: DW] = beatWord(p, pktI[p], beatI[p]);
          in_tlast[p] = (beatI[p] == plen[p] - 1);
        end else begin
          in_tvalid[p] = 1'b0;
          in_tdata[p*DW +: DW] = {$urandom, $urandom};
          in_tlast[p] = $urandom_range(0, 1);
        end
        port_mask[p] = ($urandom_range(0, 9) != 0);
      end
      out_tready = $urandom_range(0, 1);
      settle();
      req = in_tvalid & port_mask;
      expRdy = (mBusy != 0 && out_tready) ? (NP'(1) << mGrant) : '0;
      checkVal("t5_busy", busy, mBusy);
      checkVal("t5_grant", grant_idx, mGrant);
      checkVal("t5_tvalid", out_tvalid, (mBusy != 0) && in_tvalid[mGrant]);
      checkVal("t5_tready", in_tready, expRdy);
      if (mBusy != 0 && in_tvalid[mGrant]) begin
        checkVal("t5_data", out_tdata, beatWord(mGrant, pktI[mGrant], beatI[mGrant]));
        checkVal("t5_tlast", out_tlast, beatI[mGrant] == plen[mGrant] - 1);
      end
      if (out_tvalid && out_tready) gotBeats++;
      hs   = (mBusy != 0) && in_tvalid[mGrant] && out_tready;
      eopM = hs && (beatI[mGrant] == plen[mGrant] - 1);
      if (hs) begin
        if (eopM) begin
          beatI[mGrant] = 0;
          pktI[mGrant]++;
          remaining[mGrant]--;
          if (remaining[mGrant] > 0) begin
            plen[mGrant] = $urandom_range(1, 8);
            total += plen[mGrant];
          end else begin
            left--;
          end
        end else begin
          beatI[mGrant]++;
        end
      end
      if (mBusy == 0) begin
        if (req != '0) begin
          mBusy = 1;
          mGrant = pick(req, mLast);
          mLast = mGrant;
        end
      end else if (eopM) begin
        r2 = req & ~(NP'(1) << mGrant);
        if (r2 != '0) begin
          mGrant = pick(r2, mLast);
          mLast = mGrant;
        end else begin
          mBusy = 0;
        end
      end
      stepClk();
      cycles++;
    end
    checkVal("t5_all_done", left, 0);
    checkVal("t5_beat_total", gotBeats, total);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
